// File: rtl/fft_pkg.sv
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared FFT sequencer defaults, state encoding and bit-reverse helper
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fft_pkg;

    localparam int N_LOG2_DEF = 4;
    localparam int N_DEF      = 1 << N_LOG2_DEF;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_COMPUTE = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_UNLOAD  = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_LOAD    = ST_LOAD,
        S_COMPUTE = ST_COMPUTE,
        S_DRAIN   = ST_DRAIN,
        S_UNLOAD  = ST_UNLOAD,
        S_DONE    = ST_DONE
    } state_t;

    // Reverses the low 'width' bits of x; bits above 'width' come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] x, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r = r | (((x >> i) & 32'd1) << (width - 1 - i));
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_bf_addr_gen.sv
// ============================================================================
// Module   : fft_bf_addr_gen
// Brief    : Combinational radix-2 DIT butterfly address / twiddle generator
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_bf_addr_gen
    import fft_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEF
)(
    input  logic [N_LOG2-1:0] i_stage,
    input  logic [N_LOG2-2:0] i_j,
    output logic [N_LOG2-1:0] o_a,
    output logic [N_LOG2-1:0] o_b,
    output logic [N_LOG2-2:0] o_tw
);

    localparam logic [N_LOG2-1:0] c_ONE      = N_LOG2'(1);
    localparam logic [N_LOG2-1:0] c_TW_SHIFT = N_LOG2'(N_LOG2 - 1);

    logic [N_LOG2-1:0] w_j;
    logic [N_LOG2-1:0] w_half;
    logic [N_LOG2-1:0] w_pos;

    assign w_j    = {1'b0, i_j};
    assign w_half = c_ONE << i_stage;
    assign w_pos  = w_j & (w_half - c_ONE);

    // Group index is j>>s; each group spans 2*half entries of the working RAM.
    assign o_a  = ((w_j >> i_stage) << (i_stage + c_ONE)) | w_pos;
    assign o_b  = o_a + w_half;
    assign o_tw = (N_LOG2-1)'(w_pos << (c_TW_SHIFT - i_stage));

endmodule

`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
// ============================================================================
// Module   : fft_stage_sequencer
// Brief    : In-place radix-2 DIT FFT sequencer: bit-reversed load, staged
//            butterfly schedule with write-back delay line, natural-order unload
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEF,
    parameter int BF_LAT = 2,
    parameter int RD_LAT = 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_ram_wr_sel,
    output logic              o_ram_wr_en,
    output logic [N_LOG2-1:0] o_ram_wr_a,
    output logic [N_LOG2-1:0] o_ram_wr_b,
    output logic              o_ram_rd_en,
    output logic [N_LOG2-1:0] o_ram_rd_a,
    output logic [N_LOG2-1:0] o_ram_rd_b,
    output logic [N_LOG2-2:0] o_tw_addr,
    output logic              o_bf_valid,
    output logic [N_LOG2-1:0] o_stage,
    output logic              o_out_valid
);

    localparam int c_N  = 1 << N_LOG2;
    localparam int c_DL = RD_LAT + BF_LAT;

    localparam logic [N_LOG2-1:0] c_CNT_LAST   = N_LOG2'(c_N - 1);
    localparam logic [N_LOG2-1:0] c_DRAIN_LAST = N_LOG2'(c_DL - 1);
    localparam logic [N_LOG2-1:0] c_STAGE_LAST = N_LOG2'(N_LOG2 - 1);
    localparam logic [N_LOG2-2:0] c_J_LAST     = '1;

    state_t            r_state;
    state_t            w_next;
    logic [N_LOG2-1:0] r_cnt;
    logic [N_LOG2-2:0] r_j;
    logic [N_LOG2-1:0] r_stage;
    logic              r_unl_last;
    logic              r_bfv;
    logic [N_LOG2-2:0] r_tw;
    logic              r_outv;
    logic [c_DL-1:0]   r_dl_v;
    logic [N_LOG2-1:0] r_dl_a [c_DL];
    logic [N_LOG2-1:0] r_dl_b [c_DL];

    logic              w_load_acc;
    logic              w_issue;
    logic              w_unl_rd;
    logic              w_busy;
    logic              w_done;
    logic              w_in_ready;
    logic              w_wb;
    logic [N_LOG2-1:0] w_ld_addr;
    logic [N_LOG2-1:0] w_bf_a;
    logic [N_LOG2-1:0] w_bf_b;
    logic [N_LOG2-2:0] w_bf_tw;

    fft_bf_addr_gen #(
        .N_LOG2 (N_LOG2)
    ) u_addr_gen (
        .i_stage (r_stage),
        .i_j     (r_j),
        .o_a     (w_bf_a),
        .o_b     (w_bf_b),
        .o_tw    (w_bf_tw)
    );

    assign w_ld_addr = N_LOG2'(bitrev(32'(r_cnt), N_LOG2));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load_acc = 1'b0;
        w_issue    = 1'b0;
        w_unl_rd   = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_in_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_busy     = 1'b1;
                w_in_ready = 1'b1;
                w_load_acc = i_in_valid;
                if (i_in_valid && (r_cnt == c_CNT_LAST)) begin
                    w_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                w_busy  = 1'b1;
                w_issue = 1'b1;
                if (r_j == c_J_LAST) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (r_cnt == c_DRAIN_LAST) begin
                    w_next = (r_stage == c_STAGE_LAST) ? S_UNLOAD : S_COMPUTE;
                end
            end
            S_UNLOAD: begin
                // Final cycle only waits for the last read's data to appear.
                w_busy = 1'b1;
                if (r_unl_last) begin
                    w_next = S_DONE;
                end else begin
                    w_unl_rd = 1'b1;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_j        <= '0;
            r_stage    <= '0;
            r_unl_last <= 1'b0;
            r_bfv      <= 1'b0;
            r_tw       <= '0;
            r_outv     <= 1'b0;
        end else begin
            r_bfv  <= w_issue;
            r_tw   <= w_issue ? w_bf_tw : '0;
            r_outv <= w_unl_rd;
            case (r_state)
                S_LOAD: begin
                    if (w_load_acc) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_COMPUTE: begin
                    r_j <= r_j + 1'b1;
                end
                S_DRAIN: begin
                    // r_cnt doubles as the drain timer; it leaves here at zero.
                    if (r_cnt == c_DRAIN_LAST) begin
                        r_cnt <= '0;
                        if (r_stage != c_STAGE_LAST) begin
                            r_stage <= r_stage + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_UNLOAD: begin
                    if (w_unl_rd) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_CNT_LAST) begin
                            r_unl_last <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_cnt      <= '0;
                    r_j        <= '0;
                    r_stage    <= '0;
                    r_unl_last <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Write-back delay line: an issued pair exits RD_LAT+BF_LAT cycles later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dl_v <= '0;
            for (int i = 0; i < c_DL; i++) begin
                r_dl_a[i] <= '0;
                r_dl_b[i] <= '0;
            end
        end else begin
            r_dl_v    <= {r_dl_v[c_DL-2:0], w_issue};
            r_dl_a[0] <= w_bf_a;
            r_dl_b[0] <= w_bf_b;
            for (int i = 1; i < c_DL; i++) begin
                r_dl_a[i] <= r_dl_a[i-1];
                r_dl_b[i] <= r_dl_b[i-1];
            end
        end
    end

    assign w_wb = r_dl_v[c_DL-1];

    assign o_busy       = w_busy;
    assign o_done       = w_done;
    assign o_in_ready   = w_in_ready;
    assign o_ram_wr_sel = w_wb;
    assign o_ram_wr_en  = w_load_acc | w_wb;
    assign o_ram_wr_a   = w_wb ? r_dl_a[c_DL-1] : (w_load_acc ? w_ld_addr : '0);
    assign o_ram_wr_b   = w_wb ? r_dl_b[c_DL-1] : '0;
    assign o_ram_rd_en  = w_issue | w_unl_rd;
    assign o_ram_rd_a   = w_issue ? w_bf_a : (w_unl_rd ? r_cnt : '0);
    assign o_ram_rd_b   = w_issue ? w_bf_b : '0;
    assign o_tw_addr    = r_tw;
    assign o_bf_valid   = r_bfv;
    assign o_stage      = r_stage;
    assign o_out_valid  = r_outv;

endmodule

`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
// ============================================================================
// Module   : tb_fft_stage_sequencer
// Brief    : Self-checking bench: RAM/butterfly environment, direct-DFT reference
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft_stage_sequencer;

    localparam int  LG = 4;
    localparam int  N  = 16;
    localparam real PI = 3.14159265358979323846;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_start;
    logic       i_in_valid;
    logic       o_busy, o_done, o_in_ready, o_ram_wr_sel, o_ram_wr_en;
    logic       o_ram_rd_en, o_bf_valid, o_out_valid;
    logic [3:0] o_ram_wr_a, o_ram_wr_b, o_ram_rd_a, o_ram_rd_b, o_stage;
    logic [2:0] o_tw_addr;

    int n_chk;
    int n_pass;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_stage_sequencer #(
        .N_LOG2 (LG),
        .BF_LAT (2),
        .RD_LAT (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .o_ram_wr_sel (o_ram_wr_sel),
        .o_ram_wr_en  (o_ram_wr_en),
        .o_ram_wr_a   (o_ram_wr_a),
        .o_ram_wr_b   (o_ram_wr_b),
        .o_ram_rd_en  (o_ram_rd_en),
        .o_ram_rd_a   (o_ram_rd_a),
        .o_ram_rd_b   (o_ram_rd_b),
        .o_tw_addr    (o_tw_addr),
        .o_bf_valid   (o_bf_valid),
        .o_stage      (o_stage),
        .o_out_valid  (o_out_valid)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int q(input real v);
        return $rtoi(v * 16.0 + ((v < 0.0) ? -0.5 : 0.5));
    endfunction

    function automatic real twr(input int k);
        return $cos(2.0 * PI * k / N);
    endfunction

    function automatic real twi(input int k);
        return -$sin(2.0 * PI * k / N);
    endfunction

    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < LG; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // ---------------- environment: dual-port RAM + BF_LAT=2 butterfly ----------------
    real x_re[N], x_im[N];
    int  ref_re[N], ref_im[N];
    real ram_re[N], ram_im[N];
    real rda_re, rda_im, rdb_re, rdb_im;
    real p1x_re, p1x_im, p1y_re, p1y_im, p2x_re, p2x_im, p2y_re, p2y_im;
    int  ld_k = 0;

    always @(posedge clk) begin
        if (o_ram_rd_en) begin
            rda_re <= ram_re[o_ram_rd_a];
            rda_im <= ram_im[o_ram_rd_a];
            rdb_re <= ram_re[o_ram_rd_b];
            rdb_im <= ram_im[o_ram_rd_b];
        end
        if (o_bf_valid) begin
            p1x_re <= rda_re + (rdb_re * twr(int'(o_tw_addr)) - rdb_im * twi(int'(o_tw_addr)));
            p1x_im <= rda_im + (rdb_re * twi(int'(o_tw_addr)) + rdb_im * twr(int'(o_tw_addr)));
            p1y_re <= rda_re - (rdb_re * twr(int'(o_tw_addr)) - rdb_im * twi(int'(o_tw_addr)));
            p1y_im <= rda_im - (rdb_re * twi(int'(o_tw_addr)) + rdb_im * twr(int'(o_tw_addr)));
        end
        p2x_re <= p1x_re;
        p2x_im <= p1x_im;
        p2y_re <= p1y_re;
        p2y_im <= p1y_im;
        if (o_ram_wr_en) begin
            if (!o_ram_wr_sel) begin
                ram_re[o_ram_wr_a] <= x_re[ld_k];
                ram_im[o_ram_wr_a] <= x_im[ld_k];
                ld_k <= ld_k + 1;
            end else begin
                ram_re[o_ram_wr_a] <= p2x_re;
                ram_im[o_ram_wr_a] <= p2x_im;
                ram_re[o_ram_wr_b] <= p2y_re;
                ram_im[o_ram_wr_b] <= p2y_im;
            end
        end
        if (!o_busy) ld_k <= 0;
    end

    // ---------------- monitor: schedule, timing and output data ----------------
    typedef struct {
        int a;
        int b;
        int t;
    } exp_t;

    exp_t tw_q[$];
    exp_t wb_q[$];
    exp_t e;
    int   rd_idx, wb_cnt, out_idx, ld_idx, t_first, done_due;
    int   m_s, m_j, m_half, m_a;

    initial begin
        rd_idx = 0; wb_cnt = 0; out_idx = 0; ld_idx = 0; t_first = 0; done_due = -1;
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_idx = 0; wb_cnt = 0; out_idx = 0; ld_idx = 0; done_due = -1;
                tw_q.delete();
                wb_q.delete();
            end else begin
                if (o_ram_wr_en && !o_ram_wr_sel) begin
                    check("load_addr", o_ram_wr_a, brev(ld_idx));
                    ld_idx++;
                end
                if (o_ram_rd_en) begin
                    if (rd_idx < 32) begin
                        m_s    = rd_idx / 8;
                        m_j    = rd_idx % 8;
                        m_half = 1 << m_s;
                        m_a    = (m_j / m_half) * 2 * m_half + (m_j % m_half);
                        check("rd_a", o_ram_rd_a, m_a);
                        check("rd_b", o_ram_rd_b, m_a + m_half);
                        check("stage", o_stage, m_s);
                        if (m_j == 0 && m_s > 0) check("stage_order", wb_cnt, m_s * 8);
                        if (rd_idx == 0) t_first = cyc;
                        tw_q.push_back('{(m_j % m_half) * (N / (2 * m_half)), 0, cyc + 1});
                        wb_q.push_back('{m_a, m_a + m_half, cyc + 3});
                    end else if (rd_idx < 48) begin
                        check("unload_addr", o_ram_rd_a, rd_idx - 32);
                        if (rd_idx == 32) check("stage_time", cyc - t_first, 44);
                    end else begin
                        check("rd_extra", o_ram_rd_en, 0);
                    end
                    rd_idx++;
                end
                if (o_bf_valid) begin
                    if (tw_q.size() == 0) check("bf_extra", o_bf_valid, 0);
                    else begin
                        e = tw_q.pop_front();
                        check("tw_addr", o_tw_addr, e.a);
                        check("bf_time", cyc, e.t);
                    end
                end
                if (o_ram_wr_en && o_ram_wr_sel) begin
                    if (wb_q.size() == 0) check("wb_extra", o_ram_wr_sel, 0);
                    else begin
                        e = wb_q.pop_front();
                        check("wb_a", o_ram_wr_a, e.a);
                        check("wb_b", o_ram_wr_b, e.b);
                        check("wb_time", cyc, e.t);
                    end
                    wb_cnt++;
                end
                if (o_out_valid) begin
                    if (out_idx < N) begin
                        check("out_re", q(rda_re), ref_re[out_idx]);
                        check("out_im", q(rda_im), ref_im[out_idx]);
                        out_idx++;
                        if (out_idx == N) done_due = cyc + 1;
                    end else begin
                        check("out_extra", o_out_valid, 0);
                    end
                end
                if (o_done) begin
                    check("done_time", cyc, done_due);
                    check("done_busy", o_busy, 0);
                    check("done_count", out_idx, N);
                    rd_idx = 0; wb_cnt = 0; out_idx = 0; ld_idx = 0; done_due = -1;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic check_quiet(input string tag);
        check({tag, "_busy"},   o_busy, 0);
        check({tag, "_ready"},  o_in_ready, 0);
        check({tag, "_wr_en"},  o_ram_wr_en, 0);
        check({tag, "_rd_en"},  o_ram_rd_en, 0);
        check({tag, "_bfv"},    o_bf_valid, 0);
        check({tag, "_outv"},   o_out_valid, 0);
        check({tag, "_done"},   o_done, 0);
        check({tag, "_stage"},  o_stage, 0);
        check({tag, "_addrs"},  {o_ram_wr_a, o_ram_wr_b, o_ram_rd_a, o_ram_rd_b, o_tw_addr}, 0);
    endtask

    task automatic run_fft(input bit impulse, input bit gaps, input bit poke, input int abort_after);
        int  acc, guard, t0, tlast;
        real sr, si;
        for (int n = 0; n < N; n++) begin
            x_re[n] = impulse ? ((n == 0) ? 1.0 : 0.0) : real'(int'($urandom_range(15)) - 8);
            x_im[n] = impulse ? 0.0 : real'(int'($urandom_range(15)) - 8);
        end
        for (int k = 0; k < N; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < N; n++) begin
                sr += x_re[n] * twr((k * n) % N) - x_im[n] * twi((k * n) % N);
                si += x_re[n] * twi((k * n) % N) + x_im[n] * twr((k * n) % N);
            end
            ref_re[k] = q(sr);
            ref_im[k] = q(si);
        end
        @(posedge clk) #1 i_start = 1'b1;
        @(negedge clk);
        check("idle_busy", o_busy, 0);
        @(posedge clk) #1 i_start = 1'b0;
        acc = 0; guard = 0; t0 = cyc; tlast = cyc;
        while (acc < N && guard < 100) begin
            i_in_valid = gaps ? ((guard % 2) == 0) : 1'b1;
            @(negedge clk);
            if (guard == 0) check("load_busy", o_busy, 1);
            if (i_in_valid && o_in_ready) begin
                acc++;
                tlast = cyc;
            end
            @(posedge clk) #1;
            guard++;
        end
        i_in_valid = 1'b0;
        check("load_accepts", acc, N);
        if (gaps) check("load_span", tlast - t0 + 1, 31);
        @(negedge clk);
        check("ready_drop", o_in_ready, 0);
        guard = 0;
        while (!o_done && guard < 300) begin
            @(negedge clk);
            guard++;
            if (poke) i_start = (guard == 5);
            if (abort_after > 0 && guard == abort_after) begin
                reset = 1'b1;
                @(negedge clk);
                check_quiet("abort");
                reset = 1'b0;
                return;
            end
        end
        i_start = 1'b0;
        check("done_seen", o_done, 1);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        i_start = 1'b0;
        i_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;

        run_fft(1'b0, 1'b0, 1'b0, 0);
        run_fft(1'b1, 1'b0, 1'b0, 0);
        run_fft(1'b0, 1'b1, 1'b1, 0);
        run_fft(1'b0, 1'b0, 1'b0, 10);
        run_fft(1'b0, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
